// File: rtl/cva5_types.sv
// Shared types for the rename-stage free-list controller.
package cva5_types;

    localparam int PHYS_ADDR_W = 6;

    typedef logic [PHYS_ADDR_W-1:0] phys_addr_t;

    typedef enum logic {
        FL_INIT = 1'b0,
        FL_RUN  = 1'b1
    } fl_ctrl_state_t;

endpackage

// File: rtl/release_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after ptr, returns a one-hot grant and its index.
module release_rr_arbiter #(
    parameter int NUM_PORTS = 2,
    localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IW-1:0]        ptr,
    output logic [NUM_PORTS-1:0] gnt,
    output logic [IW-1:0]        gnt_idx,
    output logic                 gnt_any
);

    int idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = (int'(ptr) + i) % NUM_PORTS;
            if (!gnt_any && req[idx]) begin
                gnt_any  = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/phys_reg_free_list_ctrl.sv
// Physical-register free-list controller: init fill, release arbitration, alloc/rollback sequencing.
// Optional statistics outputs are built when FREE_LIST_STATS_EN is defined.
module phys_reg_free_list_ctrl
    import cva5_types::*;
#(
    parameter int NUM_PHYS_REGS     = 64,
    parameter int NUM_ARCH_REGS     = 32,
    parameter int NUM_RELEASE_PORTS = 2,
    localparam int PW = $clog2(NUM_PHYS_REGS),
    localparam int P  = NUM_RELEASE_PORTS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alloc_req,
    output logic            alloc_gnt,
    output logic [PW-1:0]   alloc_phys_addr,
    input  logic [P-1:0]    release_valid,
    input  logic [P*PW-1:0] release_phys_addr,
    output logic [P-1:0]    release_ack,
    input  logic            rollback_req,
    output logic            init_done,
    output logic            fl_potential_push,
    output logic            fl_push,
    output logic [PW-1:0]   fl_data_in,
    output logic            fl_pop,
    output logic            fl_rollback,
    input  logic [PW-1:0]   fl_data_out,
    input  logic            fl_valid,
    input  logic            fl_full
`ifdef FREE_LIST_STATS_EN
    ,
    output logic [31:0]     stat_alloc_stalls,
    output logic [PW:0]     stat_min_free
`endif
);

    localparam int RRW = (P > 1) ? $clog2(P) : 1;
    localparam int FILL = NUM_PHYS_REGS - NUM_ARCH_REGS;

    fl_ctrl_state_t state, next_state;
    logic [PW:0]    init_cnt;
    logic [RRW-1:0] rr_ptr;

    logic [P-1:0]   win_onehot;
    logic [RRW-1:0] win_idx;
    logic           win_any;
    logic [PW-1:0]  win_id;
    logic           win_zero;
    logic           rel_gnt;
    logic           in_init;
    logic           in_run;
    logic           init_last;

    release_rr_arbiter #(.NUM_PORTS(P)) u_arb (
        .req     (release_valid),
        .ptr     (rr_ptr),
        .gnt     (win_onehot),
        .gnt_idx (win_idx),
        .gnt_any (win_any)
    );

    assign init_last = (init_cnt == (PW+1)'(NUM_PHYS_REGS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FL_INIT;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (state == FL_INIT && init_last) next_state = FL_RUN;
    end

    // Outputs are gated by rst_n so everything reads 0 while reset is held, even though INIT pushes.
    always_comb begin
        in_init           = rst_n && (state == FL_INIT);
        in_run            = rst_n && (state == FL_RUN);
        win_id            = release_phys_addr[int'(win_idx)*PW +: PW];
        win_zero          = (win_id == '0);
        init_done         = in_run;
        alloc_gnt         = in_run && alloc_req && fl_valid && !rollback_req;
        fl_pop            = alloc_gnt;
        alloc_phys_addr   = alloc_gnt ? fl_data_out : '0;
        fl_rollback       = in_run && rollback_req;
        // ID 0 never enters the free list, so it is accepted even when the FIFO is full.
        rel_gnt           = in_run && win_any && (win_zero || !fl_full || fl_pop);
        release_ack       = rel_gnt ? win_onehot : '0;
        fl_push           = 1'b0;
        fl_data_in        = '0;
        if (in_init) begin
            fl_push    = 1'b1;
            fl_data_in = init_cnt[PW-1:0];
        end else if (rel_gnt && !win_zero) begin
            fl_push    = 1'b1;
            fl_data_in = win_id;
        end
        fl_potential_push = fl_push;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_cnt <= (PW+1)'(NUM_ARCH_REGS);
            rr_ptr   <= '0;
        end else begin
            if (state == FL_INIT && !init_last) init_cnt <= init_cnt + (PW+1)'(1);
            if (rel_gnt) rr_ptr <= (win_idx == RRW'(P - 1)) ? '0 : win_idx + RRW'(1);
        end
    end

`ifdef FREE_LIST_STATS_EN
    logic [PW:0] free_cnt;
    logic [PW:0] free_next;

    assign free_next = free_cnt + (PW+1)'(fl_push) + (PW+1)'(fl_rollback) - (PW+1)'(fl_pop);

    // The low-water mark is only meaningful once the initial fill is complete.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_alloc_stalls <= '0;
            stat_min_free     <= (PW+1)'(FILL);
            free_cnt          <= '0;
        end else begin
            free_cnt <= free_next;
            if (in_run && alloc_req && !alloc_gnt && (stat_alloc_stalls != '1))
                stat_alloc_stalls <= stat_alloc_stalls + 32'd1;
            if (state == FL_RUN && free_next < stat_min_free)
                stat_min_free <= free_next;
        end
    end
`endif

endmodule
